// File: rtl/lut_sweep_ctrl_if.sv
// Signal bundle between the LUT sweep controller and its host/LUT side.
// Optional STOP_ON_FAIL_EN adds fail_idx.
interface lut_sweep_ctrl_if #(
  parameter int N_IN = 3
);
  // Handshake: start is a level request, sampled only while the controller is
  // idle and not pulsing done; busy spans the accepted sweep and done is a
  // single-cycle completion pulse after which pass/err_cnt/table_out are valid
  // and held until the next accepted start.
  logic                   start;
  logic [(1<<N_IN)-1:0]   expected;
  logic                   lut_f;
  logic [N_IN-1:0]        lut_in;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [(1<<N_IN)-1:0]   table_out;
  logic [N_IN:0]          err_cnt;
`ifdef STOP_ON_FAIL_EN
  logic [N_IN-1:0]        fail_idx;
`endif
  logic [1:0]             state_dbg;

  modport master (
    output start, expected, lut_f,
`ifdef STOP_ON_FAIL_EN
    input  fail_idx,
`endif
    input  lut_in, busy, done, pass, table_out, err_cnt, state_dbg
  );

  modport slave (
    input  start, expected, lut_f,
`ifdef STOP_ON_FAIL_EN
    output fail_idx,
`endif
    output lut_in, busy, done, pass, table_out, err_cnt, state_dbg
  );
endinterface

// File: rtl/lut_sweep_ctrl.sv
// Walks an external N_IN-input LUT through every input vector, captures its
// truth table and grades it against a golden table. Optional: STOP_ON_FAIL_EN.
module lut_sweep_ctrl #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  lut_sweep_ctrl_if.slave bus
);

  localparam int TW = 1 << N_IN;
  localparam logic [3:0]      LAST_CNT = 4'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TW - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    CHECK   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] lut_in_q, lut_in_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TW-1:0]   gold_q, gold_d;
  logic [TW-1:0]   tab_q, tab_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            miss;
`ifdef STOP_ON_FAIL_EN
  logic [N_IN-1:0] fidx_q, fidx_d;
  logic            fail_q, fail_d;
`endif

  function automatic logic [N_IN:0] popcount(input logic [TW-1:0] v);
    logic [N_IN:0] s;
    s = '0;
    for (int i = 0; i < TW; i++) s = s + (N_IN+1)'(v[i]);
    return s;
  endfunction

`ifdef STOP_ON_FAIL_EN
  assign miss = (bus.lut_f != gold_q[idx_q]);
`else
  assign miss = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      lut_in_q <= '0;
      cnt_q    <= '0;
      gold_q   <= '0;
      tab_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
`ifdef STOP_ON_FAIL_EN
      fidx_q   <= '0;
      fail_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lut_in_q <= lut_in_d;
      cnt_q    <= cnt_d;
      gold_q   <= gold_d;
      tab_q    <= tab_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
`ifdef STOP_ON_FAIL_EN
      fidx_q   <= fidx_d;
      fail_q   <= fail_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lut_in_d = lut_in_q;
    cnt_d    = cnt_q;
    gold_d   = gold_q;
    tab_d    = tab_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
`ifdef STOP_ON_FAIL_EN
    fidx_d   = fidx_q;
    fail_d   = fail_q;
`endif
    case (state_q)
      IDLE: begin
        // The cycle showing done is still treated as part of the old sweep.
        if (bus.start && !done_q) begin
          gold_d   = bus.expected;
          idx_d    = '0;
          lut_in_d = '0;
          cnt_d    = '0;
          tab_d    = '0;
          pass_d   = 1'b0;
          err_d    = '0;
          busy_d   = 1'b1;
`ifdef STOP_ON_FAIL_EN
          fidx_d   = '0;
          fail_d   = 1'b0;
`endif
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) state_d = CAPTURE;
      end
      CAPTURE: begin
        tab_d[idx_q] = bus.lut_f;
        if (miss) begin
`ifdef STOP_ON_FAIL_EN
          fidx_d = idx_q;
          fail_d = 1'b1;
`endif
          state_d = CHECK;
        end else if (idx_q == LAST_IDX) begin
          state_d = CHECK;
        end else begin
          idx_d    = idx_q + N_IN'(1);
          lut_in_d = idx_q + N_IN'(1);
          cnt_d    = '0;
          state_d  = SETTLE;
        end
      end
      CHECK: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        pass_d  = (tab_q == gold_q);
        err_d   = popcount(tab_q ^ gold_q);
`ifdef STOP_ON_FAIL_EN
        // An early stop leaves unvisited bits at 0; report only the one miss.
        if (fail_q) begin
          pass_d = 1'b0;
          err_d  = (N_IN+1)'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.lut_in    = lut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.table_out = tab_q;
  assign bus.err_cnt   = err_q;
  assign bus.state_dbg = state_q;
`ifdef STOP_ON_FAIL_EN
  assign bus.fail_idx  = fidx_q;
`endif

endmodule
